// File: rtl/counter_pkg.sv
// Shared JK opcodes and steering helpers for the modulo-N JK up/down counter.
// Each opcode is a {J,K} pair applied to one jk_cell.
package counter_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_CLEAR  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // What the counter does on the coming edge; decoded once, then steered per bit.
   typedef enum logic [2:0] {
      STEER_HOLD,
      STEER_LOAD,
      STEER_REJECT,
      STEER_UP,
      STEER_UP_WRAP,
      STEER_DOWN,
      STEER_DOWN_WRAP
   } steer_t;

   // {J,K} pair that forces a cell to the given value regardless of its state.
   function automatic logic [1:0] jk_for_bit(input logic target);
      return target ? JK_SET : JK_CLEAR;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit rising-edge JK storage cell with asynchronous active-low reset to 0.
module jk_cell
   import counter_pkg::*;
(
   input  logic clock,
   input  logic resetnot,
   input  logic j,
   input  logic k,
   output logic q
);

   // NOTE: state is written with <= so every cell samples its J/K on the same edge.
   always_ff @(posedge clock or negedge resetnot) begin
      if (!resetnot) begin
         q <= 1'b0;
      end else begin
         unique case ({j, k})
            JK_HOLD:   q <= q;
            JK_CLEAR:  q <= 1'b0;
            JK_SET:    q <= 1'b1;
            JK_TOGGLE: q <= ~q;
            default:   q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH jk_cell instances with J/K steering.
// Define JK_COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module jk_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clock,
   input  logic             resetnot,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             load_error
);

   generate
      if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
         $error("jk_updown_counter: MODULUS must lie in 2..2**WIDTH");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MODULUS_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] toggle_up;
   logic [WIDTH-1:0] toggle_down;
   logic             at_max;
   logic             at_zero;
   logic             load_ok;
   logic             wrap_next;
   logic             load_error_next;
   steer_t           steer;

   assign at_max  = (count == MAX_COUNT);
   assign at_zero = (count == '0);
   assign load_ok = ({1'b0, load_value} < MODULUS_EXT);
   assign tc      = enable & ((up & at_max) | (~up & at_zero));

   // Ripple-style toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
   always_comb begin : toggle_chain
      logic up_chain;
      logic down_chain;
      toggle_up   = '0;
      toggle_down = '0;
      up_chain    = 1'b1;
      down_chain  = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         toggle_up[i]   = up_chain;
         toggle_down[i] = down_chain;
         up_chain       = up_chain & count[i];
         down_chain     = down_chain & ~count[i];
      end
   end

   always_comb begin
      steer = STEER_HOLD;
      if (load) begin
         steer = load_ok ? STEER_LOAD : STEER_REJECT;
      end else if (enable) begin
         if (up) begin
            steer = at_max ? STEER_UP_WRAP : STEER_UP;
         end else begin
            steer = at_zero ? STEER_DOWN_WRAP : STEER_DOWN;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      j               = '0;
      k               = '0;
      wrap_next       = 1'b0;
      load_error_next = 1'b0;
      unique case (steer)
         STEER_HOLD: begin
         end
         STEER_LOAD: begin
            for (int i = 0; i < WIDTH; i++) begin
               {j[i], k[i]} = jk_for_bit(load_value[i]);
            end
         end
         STEER_REJECT: begin
            load_error_next = 1'b1;
         end
         STEER_UP: begin
            j = toggle_up;
            k = toggle_up;
         end
         STEER_UP_WRAP: begin
`ifdef JK_COUNTER_SATURATE_EN
`else
            for (int i = 0; i < WIDTH; i++) begin
               {j[i], k[i]} = count[i] ? JK_CLEAR : JK_HOLD;
            end
            wrap_next = 1'b1;
`endif
         end
         STEER_DOWN: begin
            j = toggle_down;
            k = toggle_down;
         end
         STEER_DOWN_WRAP: begin
`ifdef JK_COUNTER_SATURATE_EN
`else
            for (int i = 0; i < WIDTH; i++) begin
               {j[i], k[i]} = jk_for_bit(MAX_COUNT[i]);
            end
            wrap_next = 1'b1;
`endif
         end
         default: begin
         end
      endcase
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         jk_cell u_cell (
            .clock    (clock),
            .resetnot (resetnot),
            .j        (j[i]),
            .k        (k[i]),
            .q        (count[i])
         );
      end
   endgenerate

   always_ff @(posedge clock or negedge resetnot) begin
      if (!resetnot) begin
         wrap       <= 1'b0;
         load_error <= 1'b0;
      end else begin
         wrap       <= wrap_next;
         load_error <= load_error_next;
      end
   end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Scoreboard bench for jk_updown_counter (WIDTH=4, MODULUS=10); honours JK_COUNTER_SATURATE_EN.
module tb_jk_updown_counter;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 10;

   typedef struct {
      logic [WIDTH-1:0] count;
      logic             wrap;
      logic             load_error;
   } expect_t;

   logic             clock;
   logic             resetnot;
   logic             enable;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             load_error;

   int      total;
   int      bad;
   int      model_count;
   expect_t sb[$];

   jk_updown_counter #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) dut (
      .clock      (clock),
      .resetnot   (resetnot),
      .enable     (enable),
      .up         (up),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .tc         (tc),
      .wrap       (wrap),
      .load_error (load_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   // One clock of stimulus: check tc against the model, predict the edge, then compare.
   task automatic step(input logic en, input logic u, input logic ld, input int lv);
      expect_t e;
      int      nxt;
      logic    exp_tc;
      enable     = en;
      up         = u;
      load       = ld;
      load_value = WIDTH'(lv);
      #1;
      exp_tc = en && ((u && model_count == MODULUS - 1) || (!u && model_count == 0));
      check("tc", int'(tc), int'(exp_tc));
      nxt          = model_count;
      e.wrap       = 1'b0;
      e.load_error = 1'b0;
      if (ld) begin
         if (lv < MODULUS) nxt = lv;
         else e.load_error = 1'b1;
      end else if (en) begin
         if (u) begin
            if (model_count == MODULUS - 1) begin
`ifdef JK_COUNTER_SATURATE_EN
               nxt = model_count;
`else
               nxt    = 0;
               e.wrap = 1'b1;
`endif
            end else begin
               nxt = model_count + 1;
            end
         end else begin
            if (model_count == 0) begin
`ifdef JK_COUNTER_SATURATE_EN
               nxt = 0;
`else
               nxt    = MODULUS - 1;
               e.wrap = 1'b1;
`endif
            end else begin
               nxt = model_count - 1;
            end
         end
      end
      e.count = WIDTH'(nxt);
      sb.push_back(e);
      @(posedge clock);
      #1;
      model_count = nxt;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("count", int'(count), int'(e.count));
         check("wrap", int'(wrap), int'(e.wrap));
         check("load_error", int'(load_error), int'(e.load_error));
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      model_count = 0;
      resetnot    = 1'b0;
      enable      = 1'b0;
      up          = 1'b1;
      load        = 1'b0;
      load_value  = '0;

      #3;
      check("reset_count", int'(count), 0);
      check("reset_wrap", int'(wrap), 0);
      check("reset_load_error", int'(load_error), 0);
      @(negedge clock);
      resetnot = 1'b1;

      // Reset mid-operation: reach 6, raise load_error, then drop reset between edges.
      step(1'b1, 1'b1, 1'b1, 6);
      step(1'b0, 1'b1, 1'b1, 15);
      #2;
      resetnot = 1'b0;
      #1;
      model_count = 0;
      check("midreset_count", int'(count), 0);
      check("midreset_wrap", int'(wrap), 0);
      check("midreset_load_error", int'(load_error), 0);
      @(negedge clock);
      resetnot = 1'b1;
      step(1'b1, 1'b1, 1'b0, 0);

      // Up wrap from 8.
      step(1'b0, 1'b1, 1'b1, 8);
      repeat (3) step(1'b1, 1'b1, 1'b0, 0);

      // Down wrap from 1.
      step(1'b0, 1'b0, 1'b1, 1);
      repeat (3) step(1'b1, 1'b0, 1'b0, 0);

      // Load beats enable; out-of-range load is rejected for one cycle.
      step(1'b1, 1'b1, 1'b1, 5);
      step(1'b1, 1'b1, 1'b1, 12);
      step(1'b0, 1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 1'b1, 10);

      // Direction flip then hold.
      step(1'b0, 1'b1, 1'b1, 3);
      repeat (2) step(1'b1, 1'b1, 1'b0, 0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 0);
      repeat (4) step(1'b0, 1'b1, 1'b0, 0);

      // Terminal value held with enable (wraps by default, saturates with the macro).
      step(1'b0, 1'b1, 1'b1, 9);
      repeat (3) step(1'b1, 1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 0);

      // Random mix of loads (including illegal values), counts and holds.
      for (int n = 0; n < 300; n++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jk_updown_counter.md
Name: jk_updown_counter

Overview:
- Synchronous modulo-N up/down counter whose state bits are one-bit JK storage cells.
- Per-bit J/K drive logic is generated from count, direction, load and wrap conditions.
- Sits directly upstream of the lab's JK flip-flop stage: it drives J/K pairs into storage cells and exposes count, terminal-count and wrap status for the next lab exercise (display/sequence control).

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2^WIDTH; an illegal value triggers an elaboration-time error.

Ports:
- clock  input  1  rising-edge clock, the single clock domain.
- resetnot  input  1  asynchronous, active-low reset.
- enable  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- load_value  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational.
- wrap  output  1  one-cycle registered pulse on wrap-around.
- load_error  output  1  one-cycle registered pulse on an out-of-range load.

Behaviour:
- Interface (already decided): one clock, `clock`; reset `resetnot`, asynchronous and active-low.
- Reset: while resetnot = 0, count = 0, wrap = 0 and load_error = 0 immediately, independent of clock.
  - First active edge is the first rising clock edge after resetnot returns to 1.
  - Reset asserted mid-operation discards any pending load or count.
- Each bit is a JK cell with the following J/K meanings:
  - J=0, K=0: hold.
  - J=0, K=1: clear.
  - J=1, K=0: set.
  - J=1, K=1: toggle.
- Priority per rising edge: load > enable > hold.
- Load (load = 1):
  - If load_value < MODULUS: bit i gets J = load_value[i], K = ~load_value[i]; count = load_value next cycle; load_error = 0.
  - If load_value >= MODULUS: all cells hold, count unchanged, load_error = 1 for exactly one cycle.
  - load is honoured regardless of enable; wrap = 0 on a load cycle.
- Count (load = 0, enable = 1):
  - Up, count < MODULUS-1: J = K = toggle_i, with toggle_i = AND of bits [i-1:0] (bit 0 always toggles). Result is count+1.
  - Up, count == MODULUS-1: set bits get J=0, K=1, so next count = 0; wrap = 1 next cycle.
  - Down, count > 0: toggle_i = AND of inverted bits [i-1:0]. Result is count-1.
  - Down, count == 0: J = MODULUS-1, K = ~(MODULUS-1), so next count = MODULUS-1; wrap = 1 next cycle.
- Hold (load = 0, enable = 0): J = K = 0 for all bits; wrap = 0; load_error = 0.
- Latency: count, wrap and load_error update one clock after the qualifying inputs are sampled.
- tc = enable & ((up & count == MODULUS-1) | (~up & count == 0)); combinational, no latency.
- Direction may change on any cycle; the new direction applies on that edge.
- MODULUS = 2^WIDTH: the wrap path equals natural binary rollover; wrap still pulses.
- Counter state is never outside 0..MODULUS-1 after reset.

Optional Feature:
- Macro: JK_COUNTER_SATURATE_EN.
- Defined: at the terminal value with enable = 1, all cells hold. count stays at MODULUS-1 (up) or 0 (down). wrap is tied to 0. tc behaves as above. Load is unaffected.
- Undefined: wrap-around behaviour as specified in Behaviour.

Decomposition:
- Shared package counter_pkg holds:
  - 2-bit JK opcode constants JK_HOLD=00, JK_CLEAR=01, JK_SET=10, JK_TOGGLE=11 (J,K order).
  - A function returning the {J,K} pair for a target bit value.
- One sub-module, jk_cell: single-bit rising-edge JK storage with asynchronous active-low reset to 0. It is instantiated WIDTH times with a generate loop.
- All J/K steering lives in the parent.

Test Plan (WIDTH=4, MODULUS=10):
- Reset mid-count: count=6, drop resetnot between edges -> count=0, wrap=0, load_error=0 immediately. After release, first enabled up edge -> count=1.
- Up wrap: load 8, enable=1, up=1 -> counts 9, then 0. tc=1 while count=9. wrap=1 only in the cycle count=0 first appears.
- Down wrap: load 1, up=0 -> counts 0, then 9. tc=1 while count=0. wrap pulses once on the transition to 9.
- Load priority and error: load=1, enable=1, load_value=5 -> count=5, no increment. Then load_value=12 -> count stays 5, load_error=1 for one cycle.
- Direction flip and hold: count=3, up=1 for 2 edges -> 5; up=0 for 3 edges -> 2; enable=0 for 4 edges -> stays 2, tc=0.
- With JK_COUNTER_SATURATE_EN: count=9, up=1, enable=1 for 3 edges -> stays 9, wrap=0, tc=1.
